// File: rtl/axi_lite_master_pkg.sv
// Shared types for the AXI-Lite master bridge: FSM state, response codes and
// the default AXI request/response structs (64-bit addr/data, 10-bit ID).
package axi_lite_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRITE_B,
    READ,
    READ_R
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef struct packed {
    logic [63:0] addr;
    logic [2:0]  prot;
    logic [3:0]  region;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [3:0]  qos;
    logic [9:0]  id;
    logic [5:0]  atop;
    logic [0:0]  user;
  } aw_chan_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [2:0]  prot;
    logic [3:0]  region;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [3:0]  qos;
    logic [9:0]  id;
    logic [0:0]  user;
  } ar_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic [0:0]  user;
  } w_chan_t;

  typedef struct packed {
    logic [9:0] id;
    logic [1:0] resp;
    logic [0:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [9:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [0:0]  user;
  } r_chan_t;

  typedef struct packed {
    logic     aw_valid;
    aw_chan_t aw;
    logic     w_valid;
    w_chan_t  w;
    logic     b_ready;
    logic     ar_valid;
    ar_chan_t ar;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

endpackage

// File: rtl/axi_lite_master_bridge.sv
// Single-outstanding req/gnt to AXI-Lite master bridge.
// Optional AXI_LITE_MASTER_ERR_EN: report resp[1] of the completing beat on err_o.
module axi_lite_master_bridge
  import axi_lite_master_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_ID         = 0,
  parameter type axi_req_t  = axi_lite_master_pkg::req_t,
  parameter type axi_resp_t = axi_lite_master_pkg::resp_t
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_i,
  output logic                        gnt_o,
  input  logic                        we_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
  input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
  output logic                        rvalid_o,
  output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
  output logic                        err_o,
  output axi_req_t                    axi_req_o,
  input  axi_resp_t                   axi_resp_i
);

  localparam logic [2:0] AXI_SIZE = 3'($clog2(AXI_DATA_WIDTH / 8));

  state_t state_q, state_d;

  logic [AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [AXI_DATA_WIDTH/8-1:0] be_q;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q;
  logic                        aw_done_q, w_done_q;
  logic                        rvalid_q;
  logic [AXI_DATA_WIDTH-1:0]   rdata_q;

  logic aw_hs_done, w_hs_done, b_hs, r_hs;

  assign aw_hs_done = aw_done_q || axi_resp_i.aw_ready;
  assign w_hs_done  = w_done_q  || axi_resp_i.w_ready;
  assign b_hs       = (state_q == WRITE_B) && axi_resp_i.b_valid;
  assign r_hs       = (state_q == READ_R)  && axi_resp_i.r_valid;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_i) state_d = we_i ? WRITE : READ;
      WRITE:   if (aw_hs_done && w_hs_done) state_d = WRITE_B;
      WRITE_B: if (axi_resp_i.b_valid) state_d = IDLE;
      READ:    if (axi_resp_i.ar_ready) state_d = READ_R;
      READ_R:  if (axi_resp_i.r_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Done flags only live inside WRITE; they clear as the FSM leaves it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (state_q == IDLE && req_i) begin
        addr_q  <= addr_i;
        be_q    <= be_i;
        wdata_q <= wdata_i;
      end
      aw_done_q <= (state_q == WRITE) && (state_d == WRITE) && aw_hs_done;
      w_done_q  <= (state_q == WRITE) && (state_d == WRITE) && w_hs_done;
      rvalid_q  <= b_hs || r_hs;
      if (r_hs) rdata_q <= axi_resp_i.r.data;
    end
  end

  always_comb begin
    gnt_o     = 1'b0;
    axi_req_o = '0;

    axi_req_o.aw.addr  = addr_q;
    axi_req_o.aw.len   = '0;
    axi_req_o.aw.size  = AXI_SIZE;
    axi_req_o.aw.burst = BURST_INCR;
    axi_req_o.aw.id    = AXI_ID_WIDTH'(AXI_ID);
    axi_req_o.w.data   = wdata_q;
    axi_req_o.w.strb   = be_q;
    axi_req_o.w.last   = 1'b1;
    axi_req_o.ar.addr  = addr_q;
    axi_req_o.ar.len   = '0;
    axi_req_o.ar.size  = AXI_SIZE;
    axi_req_o.ar.burst = BURST_INCR;
    axi_req_o.ar.id    = AXI_ID_WIDTH'(AXI_ID);

    if (!rst_i) begin
      unique case (state_q)
        IDLE:    gnt_o = req_i;
        WRITE: begin
          axi_req_o.aw_valid = !aw_done_q;
          axi_req_o.w_valid  = !w_done_q;
        end
        WRITE_B: axi_req_o.b_ready  = 1'b1;
        READ:    axi_req_o.ar_valid = 1'b1;
        READ_R:  axi_req_o.r_ready  = 1'b1;
        default: ;
      endcase
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;

`ifdef AXI_LITE_MASTER_ERR_EN
  logic err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)     err_q <= 1'b0;
    else if (b_hs) err_q <= axi_resp_i.b.resp[1];
    else if (r_hs) err_q <= axi_resp_i.r.resp[1];
    else           err_q <= 1'b0;
  end

  assign err_o = err_q;

  logic unused_resp;
  assign unused_resp = ^{axi_resp_i.b.id, axi_resp_i.b.user, axi_resp_i.b.resp[0],
                         axi_resp_i.r.id, axi_resp_i.r.last, axi_resp_i.r.user,
                         axi_resp_i.r.resp[0]};
`else
  assign err_o = 1'b0;

  logic unused_resp;
  assign unused_resp = ^{axi_resp_i.b.id, axi_resp_i.b.user, axi_resp_i.b.resp,
                         axi_resp_i.r.id, axi_resp_i.r.last, axi_resp_i.r.user,
                         axi_resp_i.r.resp};
`endif

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Directed bench for axi_lite_master_bridge; expectations follow AXI_LITE_MASTER_ERR_EN.
module tb_axi_lite_master_bridge;
  import axi_lite_master_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        gnt;
  logic        we = 1'b0;
  logic [63:0] addr = '0;
  logic [7:0]  be = '0;
  logic [63:0] wdata = '0;
  logic        rvalid;
  logic [63:0] rdata;
  logic        err;
  req_t        axi_req;
  resp_t       axi_resp = '0;

  int total = 0;
  int bad = 0;

`ifdef AXI_LITE_MASTER_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  axi_lite_master_bridge #(
    .AXI_ADDR_WIDTH(64),
    .AXI_DATA_WIDTH(64),
    .AXI_ID_WIDTH  (10),
    .AXI_ID        (0)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req),
    .gnt_o     (gnt),
    .we_i      (we),
    .addr_i    (addr),
    .be_i      (be),
    .wdata_i   (wdata),
    .rvalid_o  (rvalid),
    .rdata_o   (rdata),
    .err_o     (err),
    .axi_req_o (axi_req),
    .axi_resp_i(axi_resp)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are then driven and
  // outputs sampled a further #1 later, well away from either edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 1'b1;
    we  = 1'b1;
    tick();
    tick();
    #1;
    total++; if (gnt !== 1'b0) begin bad++; $display("FAIL reset_gnt got=%0b exp=0", gnt); end
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%0b exp=0", rvalid); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", err); end
    total++; if (rdata !== 64'h0) begin bad++; $display("FAIL reset_rdata got=%0h exp=0", rdata); end
    total++; if ({axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid, axi_req.b_ready, axi_req.r_ready} !== 5'b0)
      begin bad++; $display("FAIL reset_axi got=%0b exp=0", {axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid, axi_req.b_ready, axi_req.r_ready}); end
    req = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_same_cycle();
    req = 1'b1; we = 1'b1; addr = 64'h8000_0010; wdata = 64'hDEAD_BEEF; be = 8'h0F;
    #1;
    total++; if (gnt !== 1'b1) begin bad++; $display("FAIL wr_gnt got=%0b exp=1", gnt); end
    tick();
    req = 1'b0;
    #1;
    total++; if (gnt !== 1'b0) begin bad++; $display("FAIL wr_gnt_busy got=%0b exp=0", gnt); end
    total++; if ({axi_req.aw_valid, axi_req.w_valid} !== 2'b11) begin bad++; $display("FAIL wr_valids got=%0b exp=11", {axi_req.aw_valid, axi_req.w_valid}); end
    total++; if (axi_req.aw.addr !== 64'h8000_0010) begin bad++; $display("FAIL wr_awaddr got=%0h exp=80000010", axi_req.aw.addr); end
    total++; if (axi_req.w.data !== 64'hDEAD_BEEF) begin bad++; $display("FAIL wr_wdata got=%0h exp=deadbeef", axi_req.w.data); end
    total++; if (axi_req.w.strb !== 8'h0F) begin bad++; $display("FAIL wr_strb got=%0h exp=0f", axi_req.w.strb); end
    total++; if ({axi_req.aw.len, axi_req.aw.size, axi_req.aw.burst, axi_req.w.last} !== {8'd0, 3'd3, 2'b01, 1'b1})
      begin bad++; $display("FAIL wr_awfields got=%0h exp=%0h", {axi_req.aw.len, axi_req.aw.size, axi_req.aw.burst, axi_req.w.last}, {8'd0, 3'd3, 2'b01, 1'b1}); end
    total++; if (axi_req.aw.id !== 10'd0) begin bad++; $display("FAIL wr_awid got=%0h exp=0", axi_req.aw.id); end
    total++; if (axi_req.b_ready !== 1'b0) begin bad++; $display("FAIL wr_bready_early got=%0b exp=0", axi_req.b_ready); end
    axi_resp.aw_ready = 1'b1; axi_resp.w_ready = 1'b1;
    tick();
    axi_resp.aw_ready = 1'b0; axi_resp.w_ready = 1'b0;
    #1;
    total++; if ({axi_req.aw_valid, axi_req.w_valid, axi_req.b_ready} !== 3'b001)
      begin bad++; $display("FAIL wr_to_b got=%0b exp=001", {axi_req.aw_valid, axi_req.w_valid, axi_req.b_ready}); end
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL wr_rvalid_early got=%0b exp=0", rvalid); end
    axi_resp.b_valid = 1'b1; axi_resp.b.resp = RESP_OKAY;
    tick();
    axi_resp.b_valid = 1'b0;
    #1;
    total++; if (rvalid !== 1'b1) begin bad++; $display("FAIL wr_done got=%0b exp=1", rvalid); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL wr_err got=%0b exp=0", err); end
    total++; if (axi_req.b_ready !== 1'b0) begin bad++; $display("FAIL wr_bready_idle got=%0b exp=0", axi_req.b_ready); end
    tick();
    #1;
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL wr_pulse got=%0b exp=0", rvalid); end
  endtask

  task automatic test_write_w_late();
    req = 1'b1; we = 1'b1; addr = 64'h8000_0020; wdata = 64'h0123_4567_89AB_CDEF; be = 8'hFF;
    tick();
    req = 1'b0;
    axi_resp.aw_ready = 1'b1;
    tick();
    axi_resp.aw_ready = 1'b0;
    #1;
    total++; if ({axi_req.aw_valid, axi_req.w_valid} !== 2'b01) begin bad++; $display("FAIL wl_aw_drop got=%0b exp=01", {axi_req.aw_valid, axi_req.w_valid}); end
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      total++; if ({axi_req.aw_valid, axi_req.w_valid, axi_req.b_ready} !== 3'b010)
        begin bad++; $display("FAIL wl_hold%0d got=%0b exp=010", i, {axi_req.aw_valid, axi_req.w_valid, axi_req.b_ready}); end
      total++; if ({axi_req.w.data, axi_req.w.strb} !== {64'h0123_4567_89AB_CDEF, 8'hFF})
        begin bad++; $display("FAIL wl_payload%0d got=%0h exp=%0h", i, {axi_req.w.data, axi_req.w.strb}, {64'h0123_4567_89AB_CDEF, 8'hFF}); end
    end
    axi_resp.w_ready = 1'b1;
    tick();
    axi_resp.w_ready = 1'b0;
    #1;
    total++; if ({axi_req.aw_valid, axi_req.w_valid, axi_req.b_ready} !== 3'b001)
      begin bad++; $display("FAIL wl_to_b got=%0b exp=001", {axi_req.aw_valid, axi_req.w_valid, axi_req.b_ready}); end
    axi_resp.b_valid = 1'b1;
    tick();
    #1;
    total++; if (rvalid !== 1'b1) begin bad++; $display("FAIL wl_done got=%0b exp=1", rvalid); end
    tick();
    #1;
    total++; if ({rvalid, axi_req.b_ready} !== 2'b00) begin bad++; $display("FAIL wl_single_b got=%0b exp=00", {rvalid, axi_req.b_ready}); end
    axi_resp.b_valid = 1'b0;
  endtask

  task automatic test_read();
    req = 1'b1; we = 1'b0; addr = 64'h8000_0000;
    tick();
    req = 1'b0;
    #1;
    total++; if (axi_req.ar_valid !== 1'b1) begin bad++; $display("FAIL rd_arvalid got=%0b exp=1", axi_req.ar_valid); end
    total++; if (axi_req.ar.addr !== 64'h8000_0000) begin bad++; $display("FAIL rd_araddr got=%0h exp=80000000", axi_req.ar.addr); end
    total++; if ({axi_req.ar.len, axi_req.ar.id, axi_req.aw_valid} !== {8'd0, 10'd0, 1'b0})
      begin bad++; $display("FAIL rd_arfields got=%0h exp=0", {axi_req.ar.len, axi_req.ar.id, axi_req.aw_valid}); end
    axi_resp.ar_ready = 1'b1;
    tick();
    axi_resp.ar_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if ({axi_req.ar_valid, axi_req.r_ready, rvalid} !== 3'b010)
        begin bad++; $display("FAIL rd_wait%0d got=%0b exp=010", i, {axi_req.ar_valid, axi_req.r_ready, rvalid}); end
      tick();
    end
    axi_resp.r_valid = 1'b1; axi_resp.r.data = 64'h1234_5678; axi_resp.r.resp = RESP_OKAY;
    #1;
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL rd_latency got=%0b exp=0", rvalid); end
    tick();
    axi_resp.r_valid = 1'b0;
    #1;
    total++; if (rvalid !== 1'b1) begin bad++; $display("FAIL rd_done got=%0b exp=1", rvalid); end
    total++; if (rdata !== 64'h1234_5678) begin bad++; $display("FAIL rd_data got=%0h exp=12345678", rdata); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rd_err got=%0b exp=0", err); end
    tick();
  endtask

  task automatic test_err();
    req = 1'b1; we = 1'b1; addr = 64'h8000_0030; wdata = 64'h55; be = 8'h01;
    tick();
    req = 1'b0;
    axi_resp.aw_ready = 1'b1; axi_resp.w_ready = 1'b1;
    tick();
    axi_resp.aw_ready = 1'b0; axi_resp.w_ready = 1'b0;
    axi_resp.b_valid = 1'b1; axi_resp.b.resp = RESP_SLVERR;
    tick();
    axi_resp.b_valid = 1'b0; axi_resp.b.resp = RESP_OKAY;
    #1;
    total++; if ({rvalid, err} !== {1'b1, ERR_EXP}) begin bad++; $display("FAIL err_b got=%0b exp=%0b", {rvalid, err}, {1'b1, ERR_EXP}); end
    req = 1'b1; we = 1'b0; addr = 64'h8000_0040;
    tick();
    req = 1'b0;
    #1;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear got=%0b exp=0", err); end
    axi_resp.ar_ready = 1'b1;
    tick();
    axi_resp.ar_ready = 1'b0;
    axi_resp.r_valid = 1'b1; axi_resp.r.resp = RESP_DECERR; axi_resp.r.data = 64'hCAFE;
    tick();
    axi_resp.r_valid = 1'b0; axi_resp.r.resp = RESP_OKAY;
    #1;
    total++; if ({rvalid, err, rdata} !== {1'b1, ERR_EXP, 64'hCAFE})
      begin bad++; $display("FAIL err_r got=%0h exp=%0h", {rvalid, err, rdata}, {1'b1, ERR_EXP, 64'hCAFE}); end
    tick();
  endtask

  task automatic test_reset_mid();
    req = 1'b1; we = 1'b1; addr = 64'h8000_0050; wdata = 64'h77; be = 8'hF0;
    tick();
    req = 1'b0;
    axi_resp.aw_ready = 1'b1; axi_resp.w_ready = 1'b1;
    tick();
    axi_resp.aw_ready = 1'b0; axi_resp.w_ready = 1'b0;
    #1;
    total++; if (axi_req.b_ready !== 1'b1) begin bad++; $display("FAIL rm_in_b got=%0b exp=1", axi_req.b_ready); end
    rst = 1'b1;
    axi_resp.b_valid = 1'b1;
    tick();
    rst = 1'b0;
    axi_resp.b_valid = 1'b0;
    req = 1'b1; we = 1'b0; addr = 64'h8000_0060;
    #1;
    total++; if ({rvalid, axi_req.b_ready} !== 2'b00) begin bad++; $display("FAIL rm_abandon got=%0b exp=00", {rvalid, axi_req.b_ready}); end
    total++; if (gnt !== 1'b1) begin bad++; $display("FAIL rm_idle got=%0b exp=1", gnt); end
    req = 1'b0;
    tick();
    #1;
    total++; if ({rvalid, axi_req.ar_valid, axi_req.aw_valid} !== 3'b000)
      begin bad++; $display("FAIL rm_quiet got=%0b exp=000", {rvalid, axi_req.ar_valid, axi_req.aw_valid}); end
  endtask

  // Slave always ready and always answering: each transaction takes exactly
  // three cycles (IDLE grant, address/data phase, response phase).
  task automatic test_back_to_back();
    int unsigned phase;
    logic        is_wr;
    axi_resp.aw_ready = 1'b1; axi_resp.w_ready = 1'b1; axi_resp.ar_ready = 1'b1;
    axi_resp.b_valid = 1'b1; axi_resp.r_valid = 1'b1; axi_resp.r.data = 64'hA5A5;
    for (int k = 0; k < 12; k++) begin
      phase = k % 3;
      is_wr = ((k / 3) % 2) == 0;
      req = 1'b1; we = is_wr; addr = 64'h1000 + 64'(k / 3) * 8; wdata = 64'(k);
      #1;
      total++; if (gnt !== (phase == 0)) begin bad++; $display("FAIL b2b_gnt%0d got=%0b exp=%0b", k, gnt, phase == 0); end
      total++; if (rvalid !== (phase == 0 && k > 0)) begin bad++; $display("FAIL b2b_rvalid%0d got=%0b exp=%0b", k, rvalid, phase == 0 && k > 0); end
      total++; if (axi_req.aw_valid !== (phase == 1 && is_wr)) begin bad++; $display("FAIL b2b_aw%0d got=%0b exp=%0b", k, axi_req.aw_valid, phase == 1 && is_wr); end
      total++; if (axi_req.ar_valid !== (phase == 1 && !is_wr)) begin bad++; $display("FAIL b2b_ar%0d got=%0b exp=%0b", k, axi_req.ar_valid, phase == 1 && !is_wr); end
      if (phase == 1) begin
        if (is_wr) begin
          total++; if ({axi_req.aw.len, axi_req.aw.id, axi_req.aw.addr} !== {8'd0, 10'd0, 64'h1000 + 64'(k / 3) * 8})
            begin bad++; $display("FAIL b2b_awf%0d got=%0h", k, {axi_req.aw.len, axi_req.aw.id, axi_req.aw.addr}); end
        end else begin
          total++; if ({axi_req.ar.len, axi_req.ar.id, axi_req.ar.addr} !== {8'd0, 10'd0, 64'h1000 + 64'(k / 3) * 8})
            begin bad++; $display("FAIL b2b_arf%0d got=%0h", k, {axi_req.ar.len, axi_req.ar.id, axi_req.ar.addr}); end
        end
      end
      tick();
    end
    req = 1'b0;
    axi_resp = '0;
    #1;
    total++; if ({rvalid, gnt, rdata} !== {1'b1, 1'b0, 64'hA5A5})
      begin bad++; $display("FAIL b2b_last got=%0h exp=%0h", {rvalid, gnt, rdata}, {1'b1, 1'b0, 64'hA5A5}); end
    tick();
  endtask

  initial begin
    test_reset();
    test_write_same_cycle();
    test_write_w_late();
    test_read();
    test_err();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
